load_stall_ctrl: RTL and testbench
==================================

# load_stall_ctrl

Parametrised hazard-detection and stall controller for the 5-stage RISC-V pipeline. It sits in ID beside the register file and drives the PC write enable, the IF/ID hold, and the ID/EX bubble mux. It detects load-use hazards, and branch-in-ID operand hazards when BRANCH_IN_ID=1. Multi-cycle stalls for configurable load latency come from an internal countdown FSM, and a saturating performance counter records every stalled cycle.

## Interface
- ADDR_W, 5: register address width
- LOAD_LAT, 1: cycles a load result trails the ALU result; range 1..6
- BRANCH_IN_ID, 1: 1 = branches resolve in ID and need operand-hazard stalls; 0 = branch check disabled
- CNT_W, 16: width of the stall performance counter
- clk_i, in, 1: clock, rising edge
- rst_i, in, 1: asynchronous reset, active-low
- RS1addr_i, in, ADDR_W: rs1 of instruction in ID
- RS2addr_i, in, ADDR_W: rs2 of instruction in ID
- RS1use_i, in, 1: ID instruction reads rs1
- RS2use_i, in, 1: ID instruction reads rs2
- Branch_i, in, 1: ID instruction is a conditional branch
- IDEX_MemRead_i, in, 1: instruction in EX is a load
- IDEX_RegWrite_i, in, 1: instruction in EX writes rd
- IDEX_RDaddr_i, in, ADDR_W: rd of instruction in EX
- Flush_i, in, 1: ID instruction is being squashed this cycle
- PCWrite_o, out, 1: PC update enable
- Stall_o, out, 1: IF/ID hold
- NoOp_o, out, 1: zero the control fields into ID/EX
- StallCnt_o, out, CNT_W: total stalled cycles since reset, saturating

## Operation
- **Match rule:**
  - `m1 = RS1use_i && RS1addr_i != 0 && RS1addr_i == IDEX_RDaddr_i`.
  - m2 is the same check on RS2.
  - `m = m1 | m2`.
  - Register x0 never causes a hazard.
- **Required stall count N** (computed combinationally; the largest applicable value wins):
  - Load-use: `IDEX_MemRead_i && m` gives N = LOAD_LAT.
  - Branch on ALU result: `BRANCH_IN_ID && Branch_i && IDEX_RegWrite_i && !IDEX_MemRead_i && m` gives N = 1.
  - Branch on load result: `BRANCH_IN_ID && Branch_i && IDEX_MemRead_i && m` gives N = LOAD_LAT+1.
  - No hazard gives N = 0.
- **FSM states and counter:**
  - States are IDLE and HOLD.
  - The counter is cnt_q, sized to hold LOAD_LAT+1.
- **IDLE:**
  - If N > 0 and Flush_i = 0, assert stall this cycle. Then set cnt_q = N-1 and go to HOLD if N-1 > 0; otherwise stay in IDLE.
  - If N = 0, outputs are idle.
- **HOLD:**
  - Stall is asserted regardless of the hazard inputs, because the producer has already left EX.
  - Each cycle cnt_q decrements.
  - When cnt_q = 1 at the clock edge, the next state is IDLE.
  - HOLD inputs are not re-evaluated.
- **Stall asserted** means PCWrite_o=0, Stall_o=1, NoOp_o=1.
- **Idle** means PCWrite_o=1, Stall_o=0, NoOp_o=0.
- **Flush_i priority:**
  - Flush_i=1 overrides everything: outputs are idle this cycle and the next state is IDLE with cnt_q=0.
  - This holds in both IDLE and HOLD.
- **StallCnt_o:**
  - Increments by 1 on every edge where the stall was asserted in the preceding cycle.
  - Saturates at all-ones and never wraps.
- **Reset:**
  - Asynchronous; takes effect immediately, including mid-HOLD.
  - Sets state=IDLE, cnt_q=0, StallCnt_o=0.
  - Outputs are forced idle (PCWrite_o=1, Stall_o=0, NoOp_o=0) while rst_i=0, independent of the other inputs.

## Timing
- Stall outputs are combinational from the inputs in IDLE, so the first stall cycle is the same cycle the hazard appears. There is no added latency.
- In HOLD, outputs are decoded from registered state, so they are glitch-free from the hazard inputs (Flush_i and rst_i only).
- A hazard needing N cycles gives exactly N consecutive stall cycles, then an idle cycle in which the ID instruction advances.
- A back-to-back hazard seen on the cycle IDLE is re-entered starts a new stall sequence in that same cycle.
- The first edge after rst_i deasserts evaluates normally.
- All state updates happen on the rising edge of clk_i.

## Test plan
- **Load-use, default latency:**
  - Stimulus: LOAD_LAT=1; IDEX_MemRead_i=1, IDEX_RDaddr_i=5, RS2addr_i=5, RS2use_i=1.
  - Required: exactly 1 cycle with PCWrite_o=0, Stall_o=1, NoOp_o=1, then idle. StallCnt_o goes 0 to 1.
- **x0 and unused operands:**
  - Stimulus: rd=0 with RS1addr_i=0 and RS1use_i=1; separately, rd=7 with RS1addr_i=7 and RS1use_i=0.
  - Required: no stall in either case; StallCnt_o stays 0.
- **Branch on load, long latency:**
  - Stimulus: LOAD_LAT=3; Branch_i=1, IDEX_MemRead_i=1, rd=rs1=9, inputs then driven to a bubble (rd=0, MemRead=0).
  - Required: 4 consecutive stall cycles despite the bubble inputs, then idle. StallCnt_o=4.
- **Branch on ALU result and BRANCH_IN_ID=0:**
  - Stimulus: Branch_i=1, IDEX_RegWrite_i=1, MemRead=0, rd=rs2=3.
  - Required: 1 stall cycle. Repeating with BRANCH_IN_ID=0 gives 0 stall cycles.
- **Flush and reset mid-HOLD:**
  - Stimulus: LOAD_LAT=3 branch-on-load; assert Flush_i in stall cycle 2.
  - Required: idle outputs that cycle and IDLE thereafter; StallCnt_o=1.
  - Repeat with rst_i=0 in stall cycle 2 instead. Required: outputs idle immediately and StallCnt_o=0.
- **Saturation:**
  - Stimulus: CNT_W=4; hold a load-use hazard for 20 single-cycle stall sequences.
  - Required: StallCnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/load_stall_ctrl.sv
// Hazard detection and stall control for the ID stage: load-use and branch-in-ID
// operand hazards, multi-cycle holds via a countdown FSM, saturating stall counter.
module load_stall_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic              RS1use_i,
  input  logic              RS2use_i,
  input  logic              Branch_i,
  input  logic              IDEX_MemRead_i,
  input  logic              IDEX_RegWrite_i,
  input  logic [ADDR_W-1:0] IDEX_RDaddr_i,
  input  logic              Flush_i,
  output logic              PCWrite_o,
  output logic              Stall_o,
  output logic              NoOp_o,
  output logic [CNT_W-1:0]  StallCnt_o
);

  // Wide enough to hold LOAD_LAT+1, the longest stall sequence.
  localparam int CW = $clog2(LOAD_LAT + 2);
  localparam logic [CW-1:0] LAT    = CW'(LOAD_LAT);
  localparam logic [CW-1:0] LAT_P1 = CW'(LOAD_LAT + 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic BR_EN = (BRANCH_IN_ID != 0);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  need;
  logic           m1, m2, m;
  logic           stall;
  logic [CNT_W-1:0] perf_q;

  assign m1 = RS1use_i && (RS1addr_i != '0) && (RS1addr_i == IDEX_RDaddr_i);
  assign m2 = RS2use_i && (RS2addr_i != '0) && (RS2addr_i == IDEX_RDaddr_i);
  assign m  = m1 | m2;

  // Cases are mutually exclusive except load-use vs branch-on-load, where the later wins.
  always_comb begin
    need = '0;
    if (IDEX_MemRead_i && m)
      need = LAT;
    if (BR_EN && Branch_i && IDEX_RegWrite_i && !IDEX_MemRead_i && m)
      need = ONE;
    if (BR_EN && Branch_i && IDEX_MemRead_i && m)
      need = LAT_P1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (need > ONE) begin
            state_d = HOLD;
            cnt_d   = need - ONE;
          end else begin
            cnt_d = '0;
          end
        end
        HOLD: begin
          cnt_d = cnt_q - ONE;
          if (cnt_q <= ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall = rst_i && !Flush_i && ((state_q == HOLD) || (need != '0));
    PCWrite_o = !stall;
    Stall_o   = stall;
    NoOp_o    = stall;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      perf_q <= '0;
    else if (stall && (perf_q != '1))
      perf_q <= perf_q + 1'b1;
  end

  assign StallCnt_o = perf_q;

endmodule

// File: tb/tb_load_stall_ctrl.sv
// Directed bench: three instances cover LOAD_LAT=1/CNT_W=4, LOAD_LAT=3, and BRANCH_IN_ID=0.
module tb_load_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, br, memrd, regwr, flush;

  logic        pcw_a, stl_a, nop_a;
  logic [3:0]  cnt_a;
  logic        pcw_b, stl_b, nop_b;
  logic [15:0] cnt_b;
  logic        pcw_c, stl_c, nop_c;
  logic [15:0] cnt_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .BRANCH_IN_ID(1), .CNT_W(4)) u_a (
    .clk_i(clk), .rst_i(rst_a), .RS1addr_i(rs1), .RS2addr_i(rs2), .RS1use_i(use1),
    .RS2use_i(use2), .Branch_i(br), .IDEX_MemRead_i(memrd), .IDEX_RegWrite_i(regwr),
    .IDEX_RDaddr_i(rd), .Flush_i(flush), .PCWrite_o(pcw_a), .Stall_o(stl_a),
    .NoOp_o(nop_a), .StallCnt_o(cnt_a));

  load_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .BRANCH_IN_ID(1), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst_b), .RS1addr_i(rs1), .RS2addr_i(rs2), .RS1use_i(use1),
    .RS2use_i(use2), .Branch_i(br), .IDEX_MemRead_i(memrd), .IDEX_RegWrite_i(regwr),
    .IDEX_RDaddr_i(rd), .Flush_i(flush), .PCWrite_o(pcw_b), .Stall_o(stl_b),
    .NoOp_o(nop_b), .StallCnt_o(cnt_b));

  load_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .BRANCH_IN_ID(0), .CNT_W(16)) u_c (
    .clk_i(clk), .rst_i(rst_c), .RS1addr_i(rs1), .RS2addr_i(rs2), .RS1use_i(use1),
    .RS2use_i(use2), .Branch_i(br), .IDEX_MemRead_i(memrd), .IDEX_RegWrite_i(regwr),
    .IDEX_RDaddr_i(rd), .Flush_i(flush), .PCWrite_o(pcw_c), .Stall_o(stl_c),
    .NoOp_o(nop_c), .StallCnt_o(cnt_c));

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Stall triple packed as {PCWrite, Stall, NoOp}: 3'b011 = stall, 3'b100 = idle.
  task automatic chk_a(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, pcw_a, stl_a, nop_a}, {29'd0, exp});
  endtask
  task automatic chk_b(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, pcw_b, stl_b, nop_b}, {29'd0, exp});
  endtask
  task automatic chk_c(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, pcw_c, stl_c, nop_c}, {29'd0, exp});
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble;
    rs1 = '0; rs2 = '0; rd = '0; use1 = 1'b0; use2 = 1'b0;
    br = 1'b0; memrd = 1'b0; regwr = 1'b0; flush = 1'b0;
  endtask

  task automatic reset_all;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    cyc(); cyc();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  localparam logic [2:0] STL = 3'b011;
  localparam logic [2:0] IDL = 3'b100;

  initial begin
    bubble();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    cyc();
    // Hazard inputs driven while held in reset: outputs must stay idle.
    memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1;
    #1;
    chk_a("rst_forced_idle", IDL);
    chk("rst_cnt", cnt_a, 0);
    cyc();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;

    // Load-use, LOAD_LAT=1
    chk_a("ld_use_stall", STL);
    chk("ld_use_cnt0", cnt_a, 0);
    cyc(); bubble(); #1;
    chk_a("ld_use_idle", IDL);
    chk("ld_use_cnt1", cnt_a, 1);

    // x0 and unused operand
    reset_all(); bubble();
    memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; use1 = 1'b1; #1;
    chk_a("x0_no_stall", IDL);
    cyc();
    rd = 5'd7; rs1 = 5'd7; use1 = 1'b0; #1;
    chk_a("unused_no_stall", IDL);
    cyc(); bubble(); #1;
    chk("x0_cnt", cnt_a, 0);

    // Branch on ALU result, with and without branch checking
    reset_all(); bubble();
    br = 1'b1; regwr = 1'b1; rd = 5'd3; rs2 = 5'd3; use2 = 1'b1; #1;
    chk_a("br_alu_stall", STL);
    chk_c("br_alu_off_idle", IDL);
    cyc(); bubble(); #1;
    chk_a("br_alu_idle", IDL);
    chk("br_alu_cnt", cnt_a, 1);
    chk("br_alu_off_cnt", cnt_c, 0);

    // Branch on load, LOAD_LAT=3: four stalls despite bubble inputs
    reset_all(); bubble();
    br = 1'b1; memrd = 1'b1; rd = 5'd9; rs1 = 5'd9; use1 = 1'b1; #1;
    chk_b("br_ld_stall1", STL);
    cyc(); bubble(); #1;
    chk_b("br_ld_stall2", STL);
    cyc(); #1;
    chk_b("br_ld_stall3", STL);
    cyc(); #1;
    chk_b("br_ld_stall4", STL);
    cyc(); #1;
    chk_b("br_ld_idle", IDL);
    chk("br_ld_cnt", cnt_b, 4);
    cyc(); #1;
    chk_b("br_ld_idle2", IDL);

    // Flush in stall cycle 2
    reset_all(); bubble();
    br = 1'b1; memrd = 1'b1; rd = 5'd9; rs1 = 5'd9; use1 = 1'b1; #1;
    chk_b("fl_stall1", STL);
    cyc(); bubble(); flush = 1'b1; #1;
    chk_b("fl_idle_now", IDL);
    cyc(); flush = 1'b0; #1;
    chk_b("fl_idle_after", IDL);
    chk("fl_cnt", cnt_b, 1);
    cyc(); #1;
    chk_b("fl_idle_after2", IDL);

    // Reset in stall cycle 2
    reset_all(); bubble();
    br = 1'b1; memrd = 1'b1; rd = 5'd9; rs1 = 5'd9; use1 = 1'b1; #1;
    chk_b("mr_stall1", STL);
    cyc(); bubble(); #1;
    chk_b("mr_stall2", STL);
    rst_b = 1'b0; #1;
    chk_b("mr_idle_now", IDL);
    chk("mr_cnt_now", cnt_b, 0);
    cyc(); rst_b = 1'b1; #1;
    chk_b("mr_idle_after", IDL);
    cyc(); #1;
    chk_b("mr_idle_after2", IDL);
    chk("mr_cnt_after", cnt_b, 0);

    // Saturation with CNT_W=4
    reset_all(); bubble();
    for (int i = 0; i < 20; i++) begin
      memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1; #1;
      chk_a("sat_stall", STL);
      cyc(); bubble(); #1;
      chk("sat_cnt", cnt_a, (i + 1 > 15) ? 15 : i + 1);
      cyc();
    end
    chk("sat_final", cnt_a, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
